// File: rtl/alu_accumulator_sequencer.sv
// alu_accumulator_sequencer
// Turns the combinational 16-bit ALU into a chained calculator. A command is
// accepted in IDLE, the ALU settles in EXEC while its outputs are captured,
// and the accumulator, error status and op counter update in WB.
// acc[15:0] is fed back as the ALU A operand.
module alu_accumulator_sequencer #(
  parameter int ACC_W = 32,
  parameter int OPD_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_opcode,
  input  logic [OPD_W-1:0] cmd_operand,
  output logic [OPD_W-1:0] alu_a,
  output logic [OPD_W-1:0] alu_b,
  output logic [3:0]       alu_opcode,
  input  logic [ACC_W-1:0] alu_result,
  input  logic [1:0]       alu_error,
  output logic [ACC_W-1:0] acc,
  output logic             acc_valid,
  output logic [1:0]       err_last,
  output logic [1:0]       err_sticky,
  output logic             busy,
  output logic [15:0]      op_count
);

  localparam logic [3:0] OP_NOOP  = 4'b0000;
  localparam logic [3:0] OP_CLEAR = 4'b0001;
  localparam logic [3:0] OP_LOAD  = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0100;
  localparam logic [3:0] OP_SUB   = 4'b0101;
  localparam logic [3:0] OP_MUL   = 4'b0110;
  localparam logic [3:0] OP_DIV   = 4'b0111;
  localparam logic [3:0] OP_MOD   = 4'b1000;

  typedef enum logic [1:0] {IDLE, EXEC, WB} stateT;

  typedef struct packed {
    logic [3:0]       opcode;
    logic [OPD_W-1:0] operand;
  } cmdT;

  stateT            state, stateNext;
  cmdT              cmdReg;
  logic [ACC_W-1:0] resultCap;
  logic [1:0]       errorCap;
  logic             accept;

  logic [ACC_W-1:0] accNext;
  logic [1:0]       errLastNext;
  logic [1:0]       errStickyNext;

  assign accept = cmd_valid & cmd_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // Next-state: fixed three-cycle walk once a command is taken
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (accept) stateNext = EXEC;
      EXEC:    stateNext = WB;
      WB:      stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // FSM outputs: only IDLE can take a command, so valid held later is dropped
  always_comb begin
    cmd_ready = (state == IDLE);
    busy      = (state != IDLE);
  end

  // Accept: latch the command and drive registered operands into the ALU
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmdReg     <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
    end else if (accept) begin
      cmdReg.opcode  <= cmd_opcode;
      cmdReg.operand <= cmd_operand;
      alu_a          <= acc[OPD_W-1:0];
      alu_b          <= cmd_operand;
      alu_opcode     <= cmd_opcode;
    end
  end

  // Capture the settled ALU outputs at the end of EXEC
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resultCap <= '0;
      errorCap  <= '0;
    end else if (state == EXEC) begin
      resultCap <= alu_result;
      errorCap  <= alu_error;
    end
  end

  // Writeback decode: what acc and the error flags become at the end of WB
  always_comb begin
    accNext       = acc;
    errLastNext   = 2'b00;
    errStickyNext = err_sticky;
    unique case (cmdReg.opcode)
      OP_CLEAR: begin
        accNext       = '0;
        errStickyNext = 2'b00;
      end
      OP_LOAD: begin
        accNext = {{(ACC_W-OPD_W){cmdReg.operand[OPD_W-1]}}, cmdReg.operand};
      end
      OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD: begin
        errLastNext   = errorCap;
        errStickyNext = err_sticky | errorCap;
        // Divide-by-zero leaves acc alone; overflow still stores the wrapped value
        if (!errorCap[1]) accNext = resultCap;
      end
      default: begin
        // NOOP and unassigned opcodes: ALU output is ignored
        accNext = acc;
      end
    endcase
  end

  // Writeback registers and the one-cycle completion pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc        <= '0;
      acc_valid  <= 1'b0;
      err_last   <= 2'b00;
      err_sticky <= 2'b00;
      op_count   <= '0;
    end else begin
      acc_valid <= (state == WB);
      if (state == WB) begin
        acc        <= accNext;
        err_last   <= errLastNext;
        err_sticky <= errStickyNext;
        op_count   <= op_count + 16'd1;
      end
    end
  end

endmodule
